// File: rtl/rr_bus_arbiter_if.sv
// Shared-bus arbitration handshake: request/release from masters,
// grant and status back from the arbiter.
interface rr_bus_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic             enable;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             bus_busy;
    logic             timeout;

    modport master (
        output enable, req, done,
        input  gnt, gnt_id, bus_busy, timeout
    );

    modport slave (
        input  enable, req, done,
        output gnt, gnt_id, bus_busy, timeout
    );
endinterface

// File: rtl/rr_bus_arbiter.sv
// Round-robin shared-bus arbiter with hold limit and one-cycle
// turnaround between owners.
module rr_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    rr_bus_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);
    localparam logic [ID_W:0]     NREQ_W   = (ID_W + 1)'(N_REQ);
    localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0]  ONE      = N_REQ'(1);

    logic [1:0]        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [ID_W-1:0]   ptr;
    logic [N_REQ-1:0]  gnt_q;
    logic [ID_W-1:0]   gnt_id_q;
    logic              busy_q;
    logic              timeout_q;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [ID_W-1:0]    off;
    logic [ID_W:0]      sum;
    logic [ID_W-1:0]    pick_id;
    logic               pick_vld;

    logic            rel_norm;
    logic            rel_force;
    logic [ID_W-1:0] nxt_ptr;

    // Rotate requests so bit 0 is the master at ptr; first set bit wins.
    assign req_dbl = {bus.req, bus.req} >> ptr;
    assign req_rot = req_dbl[N_REQ-1:0];

    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) off = ID_W'(i);
        end
    end

    assign sum      = {1'b0, ptr} + {1'b0, off};
    assign pick_id  = (sum >= NREQ_W) ? ID_W'(sum - NREQ_W)
                                      : sum[ID_W-1:0];
    assign pick_vld = |bus.req;

    assign rel_norm  = bus.done[gnt_id_q] | ~bus.req[gnt_id_q];
    assign rel_force = ~rel_norm & (hold_cnt == HOLD_LIM);
    assign nxt_ptr   = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            hold_cnt  <= '0;
            ptr       <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.enable && pick_vld) begin
                        gnt_q    <= ONE << pick_id;
                        gnt_id_q <= pick_id;
                        busy_q   <= 1'b1;
                        hold_cnt <= '0;
                        state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    unique case (1'b1)
                        rel_norm, rel_force: begin
                            gnt_q     <= '0;
                            busy_q    <= 1'b0;
                            ptr       <= nxt_ptr;
                            timeout_q <= rel_force;
                            state     <= S_GAP;
                        end
                        default: hold_cnt <= hold_cnt + 1'b1;
                    endcase
                end
                S_GAP:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.gnt_id   = gnt_id_q;
    assign bus.bus_busy = busy_q;
    assign bus.timeout  = timeout_q;

endmodule
